regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 14 +
 rtl/regfile_mp_rdport.sv | 39 +++
 rtl/regfile_mp.sv | 87 ++++++++
 tb/tb_regfile_mp.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and FSM state encoding for the
// multi-port register file (regfile_mp) and its read-port slice.
package regfile_mp_pkg;

    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 5;
    localparam int NRD_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_rdport.sv
// regfile_mp_rdport: one combinational read port. Selects the addressed
// entry, forces entry 0 (and everything during reset) to zero and, when
// REGFILE_MP_BYPASS_EN is defined, forwards same-cycle write data
// (wd1 over wd0 over array) while the file is idle.
module regfile_mp_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                         rst,
    input  logic                         idle,
    input  logic [AW-1:0]                addr,
    input  logic [(1<<AW)-1:0][DW-1:0]   entries,
    input  logic                         we0,
    input  logic [AW-1:0]                wa0,
    input  logic [DW-1:0]                wd0,
    input  logic                         we1,
    input  logic [AW-1:0]                wa1,
    input  logic [DW-1:0]                wd1,
    output logic [DW-1:0]                data
);

    // Address mux, optional bypass, then zero forcing (which has the last word).
    always_comb begin
        data = entries[addr];
`ifdef REGFILE_MP_BYPASS_EN
        if (idle && we0 && (wa0 == addr)) data = wd0;
        if (idle && we1 && (wa1 == addr)) data = wd1;
`endif
        if (rst || (addr == '0)) data = '0;
    end

`ifndef REGFILE_MP_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{idle, we0, wa0, wd0, we1, wa1, wd1};
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2**AW x DW register file with NRD combinational read ports,
// two write ports (port 1 wins on conflict), hard-wired zero entry and a
// sequenced clear (one entry per cycle) with busy/done handshake.
// Optional macro: REGFILE_MP_BYPASS_EN enables write-to-read forwarding.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int NRD = NRD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*DW-1:0]   rd,
    input  logic                we0,
    input  logic                we1,
    input  logic [AW-1:0]       wa0,
    input  logic [AW-1:0]       wa1,
    input  logic [DW-1:0]       wd0,
    input  logic [DW-1:0]       wd1,
    input  logic                clr,
    output logic                busy,
    output logic                done
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] mem;
    state_t                   state;
    logic [AW-1:0]            ptr;
    logic                     idle;

    assign idle = (state == ST_IDLE);
    assign busy = (state == ST_CLEAR);

    // Array writes and clear sequencer; writes are only honoured in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            state <= ST_IDLE;
            ptr   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (we0 && (wa0 != '0)) mem[wa0] <= wd0;
                    if (we1 && (wa1 != '0)) mem[wa1] <= wd1;
                    if (clr) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + AW'(1);
                    if (ptr == '1) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_mp_rdport #(
            .DW (DW),
            .AW (AW)
        ) u_rdport (
            .rst     (rst),
            .idle    (idle),
            .addr    (ra[k*AW +: AW]),
            .entries (mem),
            .we0     (we0),
            .wa0     (wa0),
            .wd0     (wd0),
            .we1     (we1),
            .wa1     (wa1),
            .wd1     (wd1),
            .data    (rd[k*DW +: DW])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (DW=32, AW=5, NRD=2).
// Read expectations come from a bench-side model of the array and are
// queued in a scoreboard, then compared when the read data is sampled.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic              we0, we1;
    logic [AW-1:0]     wa0, wa1;
    logic [DW-1:0]     wd0, wd1;
    logic              clr;
    logic              busy, done;

    regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
        .clk  (clk),
        .rst  (rst),
        .ra   (ra),
        .rd   (rd),
        .we0  (we0),
        .we1  (we1),
        .wa0  (wa0),
        .wa1  (wa1),
        .wd0  (wd0),
        .wd1  (wd1),
        .clr  (clr),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        int            port;
        logic [DW-1:0] exp;
    } sb_t;

    sb_t           sb[$];
    logic [DW-1:0] mdl[32];
    int            n_checks = 0;
    int            n_errors = 0;
    int            busy_cnt = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int port, input logic [DW-1:0] exp);
        sb_t e;
        e.tag = tag; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, rd[e.port*DW +: DW], e.exp);
        end
    endtask

    // Reads address a on port 0 and b on port 1, expecting model contents.
    task automatic rd2(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
        ra = {b, a};
        push(tag, 0, mdl[a]);
        push(tag, 1, mdl[b]);
        drain();
    endtask

    task automatic wr(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        step();
        if (e0 && a0 != 0) mdl[a0] = d0;
        if (e1 && a1 != 0) mdl[a1] = d1;
        we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic fill();
        for (int i = 1; i < 32; i++) wr(1'b1, AW'(i), 32'hC0DE_0000 | i, 1'b0, '0, '0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        rst = 1'b1; clr = 1'b0; we0 = 1'b0; we1 = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;

        // Reset state
        #12;
        ra = {5'd5, 5'd3};
        push("rst_rd", 0, '0); push("rst_rd", 1, '0);
        drain();
        check("rst_busy", DW'(busy), '0);
        check("rst_done", DW'(done), '0);
        #8 rst = 1'b0;

        // Write then read on every port
        wr(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0);
        rd2("wr3", 5'd3, 5'd3);
        check("wr3_lit", rd[0 +: DW], 32'hDEADBEEF);

        // Conflict: port 1 wins; address 0 stays zero
        wr(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        rd2("conflict", 5'd7, 5'd0);
        check("conflict_lit", rd[0 +: DW], 32'h22);
        wr(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h55);
        rd2("zero_reg", 5'd0, 5'd0);

        // Same-cycle read of an address being written
        wr(1'b1, 5'd9, 32'h1234_5678, 1'b0, '0, '0);
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5A5A5; ra = {5'd9, 5'd9};
`ifdef REGFILE_MP_BYPASS_EN
        push("byp_same", 0, 32'hA5A5A5A5);
`else
        push("byp_same", 0, 32'h1234_5678);
`endif
        drain();
        step();
        we0 = 1'b0;
        mdl[9] = 32'hA5A5A5A5;
        rd2("byp_next", 5'd9, 5'd9);
`ifdef REGFILE_MP_BYPASS_EN
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h2;
        ra = {5'd0, 5'd4};
        push("byp_prio", 0, 32'h2); push("byp_zero", 1, '0);
        drain();
        step();
        we0 = 1'b0; we1 = 1'b0; mdl[4] = 32'h2;
`endif

        // Random dual-port traffic against the model
        for (int i = 0; i < 40; i++) begin
            wr($urandom_range(0, 1) == 1, AW'($urandom), $urandom,
               $urandom_range(0, 1) == 1, AW'($urandom), $urandom);
            rd2("rand", AW'($urandom), AW'($urandom));
        end
        for (int i = 0; i < 32; i++) rd2("sweep", AW'(i), AW'(31 - i));

        // Sequenced clear with a dropped write and a mid-clear read
        fill();
        busy_cnt = 0; done_cnt = 0;
        clr = 1'b1; step(); clr = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 6) begin
                ra = {5'd20, 5'd3};
                push("mid_clr_done", 0, '0);
                push("mid_clr_old", 1, mdl[20]);
                drain();
            end
            if (n == 10) begin we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hFFFF; end
            if (n == 11) begin
                ra = {5'd2, 5'd2};
                push("clr_drop", 0, '0);
                drain();
            end
            step();
            we0 = 1'b0;
        end
        check("clr_busy_len", DW'(busy_cnt), 32);
        check("clr_done_now", DW'(done), 1);
        step(); step();
        check("clr_done_once", DW'(done_cnt), 1);
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int i = 0; i < 32; i++) rd2("after_clr", AW'(i), AW'(31 - i));

        // Clear re-request on cycle 5 is ignored
        fill();
        busy_cnt = 0; done_cnt = 0;
        clr = 1'b1; step(); clr = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            clr = (n == 5);
            step();
        end
        clr = 1'b0;
        repeat (5) step();
        check("rereq_busy_len", DW'(busy_cnt), 32);
        check("rereq_done_once", DW'(done_cnt), 1);
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        rd2("rereq_rd", 5'd10, 5'd31);

        // Abort a clear with reset
        fill();
        clr = 1'b1; step(); clr = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #1;
        check("abort_busy", DW'(busy), '0);
        ra = {5'd30, 5'd20};
        push("abort_rd_rst", 0, '0); push("abort_rd_rst", 1, '0);
        drain();
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (40) step();
        check("abort_no_done", DW'(done_cnt), '0);
        check("abort_idle", DW'(busy), '0);
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int i = 0; i < 32; i++) rd2("abort_rd", AW'(i), AW'(31 - i));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
